// File: rtl/sbox_array_engine.sv
// sbox_array_engine: AES forward/inverse byte substitution over a block,
// SBOX_COUNT bytes per cycle, valid/ready handshake on both sides.
module sbox_array_engine #(
    parameter int BYTES      = 16,
    parameter int SBOX_COUNT = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [8*BYTES-1:0] in_data,
    input  logic               in_inv,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [8*BYTES-1:0] out_data,
    output logic               busy
);

    localparam int BEATS = BYTES / SBOX_COUNT;
    localparam int CW    = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam logic [CW-1:0] LAST = CW'(BEATS - 1);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] BUSY = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    logic [1:0]         state_q, state_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [8*BYTES-1:0] data_q, data_d;
    logic               inv_q, inv_d;
    logic [8*BYTES-1:0] res_q, res_d;

    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a,
                                        input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = xtime(x);
        end
        return p;
    endfunction

    // x^254 is the GF(2^8) inverse and maps 0 to 0, as the S-box requires
    function automatic logic [7:0] ginv(input logic [7:0] x);
        logic [7:0] sq;
        logic [7:0] acc;
        sq  = gmul(x, x);
        acc = sq;
        for (int i = 0; i < 6; i++) begin
            sq  = gmul(sq, sq);
            acc = gmul(acc, sq);
        end
        return acc;
    endfunction

    function automatic logic [7:0] rotl(input logic [7:0] a, input int n);
        return (a << n) | (a >> (8 - n));
    endfunction

    function automatic logic [7:0] sub(input logic [7:0] x, input logic inv);
        logic [7:0] b;
        if (inv) begin
            b = rotl(x, 1) ^ rotl(x, 3) ^ rotl(x, 6) ^ 8'h05;
            return ginv(b);
        end
        b = ginv(x);
        return b ^ rotl(b, 1) ^ rotl(b, 2) ^ rotl(b, 3) ^ rotl(b, 4) ^ 8'h63;
    endfunction

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        data_d  = data_q;
        inv_d   = inv_q;
        res_d   = res_q;
        unique case (state_q)
            IDLE: begin
                if (in_valid) begin
                    data_d  = in_data;
                    inv_d   = in_inv;
                    cnt_d   = '0;
                    state_d = BUSY;
                end
            end
            BUSY: begin
                for (int k = 0; k < SBOX_COUNT; k++) begin
                    res_d[8*(int'(cnt_q)*SBOX_COUNT+k) +: 8] =
                        sub(data_q[8*(int'(cnt_q)*SBOX_COUNT+k) +: 8], inv_q);
                end
                if (cnt_q == LAST) state_d = DONE;
                else cnt_d = cnt_q + CW'(1);
            end
            DONE: begin
                if (out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            data_q  <= '0;
            inv_q   <= 1'b0;
            res_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            data_q  <= data_d;
            inv_q   <= inv_d;
            res_q   <= res_d;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign busy      = (state_q != IDLE);
    assign out_data  = res_q;

endmodule

// File: tb/tb_sbox_array_engine.sv
// tb_sbox_array_engine: directed checks of sbox_array_engine with four
// SBOX_COUNT settings (4, 16, 1, 8) running side by side on one stimulus.
module tb_sbox_array_engine;

    localparam logic [7:0] SB [256] = '{
        8'h63,8'h7c,8'h77,8'h7b,8'hf2,8'h6b,8'h6f,8'hc5,8'h30,8'h01,8'h67,8'h2b,8'hfe,8'hd7,8'hab,8'h76,
        8'hca,8'h82,8'hc9,8'h7d,8'hfa,8'h59,8'h47,8'hf0,8'had,8'hd4,8'ha2,8'haf,8'h9c,8'ha4,8'h72,8'hc0,
        8'hb7,8'hfd,8'h93,8'h26,8'h36,8'h3f,8'hf7,8'hcc,8'h34,8'ha5,8'he5,8'hf1,8'h71,8'hd8,8'h31,8'h15,
        8'h04,8'hc7,8'h23,8'hc3,8'h18,8'h96,8'h05,8'h9a,8'h07,8'h12,8'h80,8'he2,8'heb,8'h27,8'hb2,8'h75,
        8'h09,8'h83,8'h2c,8'h1a,8'h1b,8'h6e,8'h5a,8'ha0,8'h52,8'h3b,8'hd6,8'hb3,8'h29,8'he3,8'h2f,8'h84,
        8'h53,8'hd1,8'h00,8'hed,8'h20,8'hfc,8'hb1,8'h5b,8'h6a,8'hcb,8'hbe,8'h39,8'h4a,8'h4c,8'h58,8'hcf,
        8'hd0,8'hef,8'haa,8'hfb,8'h43,8'h4d,8'h33,8'h85,8'h45,8'hf9,8'h02,8'h7f,8'h50,8'h3c,8'h9f,8'ha8,
        8'h51,8'ha3,8'h40,8'h8f,8'h92,8'h9d,8'h38,8'hf5,8'hbc,8'hb6,8'hda,8'h21,8'h10,8'hff,8'hf3,8'hd2,
        8'hcd,8'h0c,8'h13,8'hec,8'h5f,8'h97,8'h44,8'h17,8'hc4,8'ha7,8'h7e,8'h3d,8'h64,8'h5d,8'h19,8'h73,
        8'h60,8'h81,8'h4f,8'hdc,8'h22,8'h2a,8'h90,8'h88,8'h46,8'hee,8'hb8,8'h14,8'hde,8'h5e,8'h0b,8'hdb,
        8'he0,8'h32,8'h3a,8'h0a,8'h49,8'h06,8'h24,8'h5c,8'hc2,8'hd3,8'hac,8'h62,8'h91,8'h95,8'he4,8'h79,
        8'he7,8'hc8,8'h37,8'h6d,8'h8d,8'hd5,8'h4e,8'ha9,8'h6c,8'h56,8'hf4,8'hea,8'h65,8'h7a,8'hae,8'h08,
        8'hba,8'h78,8'h25,8'h2e,8'h1c,8'ha6,8'hb4,8'hc6,8'he8,8'hdd,8'h74,8'h1f,8'h4b,8'hbd,8'h8b,8'h8a,
        8'h70,8'h3e,8'hb5,8'h66,8'h48,8'h03,8'hf6,8'h0e,8'h61,8'h35,8'h57,8'hb9,8'h86,8'hc1,8'h1d,8'h9e,
        8'he1,8'hf8,8'h98,8'h11,8'h69,8'hd9,8'h8e,8'h94,8'h9b,8'h1e,8'h87,8'he9,8'hce,8'h55,8'h28,8'hdf,
        8'h8c,8'ha1,8'h89,8'h0d,8'hbf,8'he6,8'h42,8'h68,8'h41,8'h99,8'h2d,8'h0f,8'hb0,8'h54,8'hbb,8'h16
    };

    localparam int EXPLAT [4] = '{5, 2, 17, 3};

    logic         clk       = 1'b0;
    logic         rst_n     = 1'b1;
    logic         in_valid  = 1'b0;
    logic         in_inv    = 1'b0;
    logic         out_ready = 1'b1;
    logic [127:0] in_data   = '0;

    logic         ir [4];
    logic         ov [4];
    logic         bz [4];
    logic [127:0] od [4];

    int           nvec = 0;
    int           nerr = 0;
    int           lat [4];
    logic [127:0] res [4];

    always #5 clk = ~clk;

    sbox_array_engine #(.BYTES(16), .SBOX_COUNT(4)) u0 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ir[0]),
        .in_data(in_data), .in_inv(in_inv), .out_valid(ov[0]),
        .out_ready(out_ready), .out_data(od[0]), .busy(bz[0]));
    sbox_array_engine #(.BYTES(16), .SBOX_COUNT(16)) u1 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ir[1]),
        .in_data(in_data), .in_inv(in_inv), .out_valid(ov[1]),
        .out_ready(out_ready), .out_data(od[1]), .busy(bz[1]));
    sbox_array_engine #(.BYTES(16), .SBOX_COUNT(1)) u2 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ir[2]),
        .in_data(in_data), .in_inv(in_inv), .out_valid(ov[2]),
        .out_ready(out_ready), .out_data(od[2]), .busy(bz[2]));
    sbox_array_engine #(.BYTES(16), .SBOX_COUNT(8)) u3 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ir[3]),
        .in_data(in_data), .in_inv(in_inv), .out_valid(ov[3]),
        .out_ready(out_ready), .out_data(od[3]), .busy(bz[3]));

    task automatic chk(input string tag, input logic [127:0] obs,
                       input logic [127:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [127:0] fwdblk(input logic [127:0] d);
        logic [127:0] r;
        for (int j = 0; j < 16; j++) r[8*j +: 8] = SB[d[8*j +: 8]];
        return r;
    endfunction

    // Pulse one block into all instances, record per-instance latency
    // (negedges after the accepting edge) and result, then check latency.
    task automatic run(input logic [127:0] d, input logic inv, input bit tog);
        int  n;
        bit  seen [4];
        n = 0;
        while (!(ir[0] && ir[1] && ir[2] && ir[3]) && n < 40) begin
            @(negedge clk);
            n++;
        end
        in_data  = d;
        in_inv   = inv;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        for (int k = 0; k < 4; k++) begin
            seen[k] = 1'b0;
            lat[k]  = 0;
            res[k]  = 'x;
        end
        for (n = 1; n <= 40; n++) begin
            if (tog) begin
                in_inv  = ~inv;
                in_data = ~d;
            end
            for (int k = 0; k < 4; k++) begin
                if (ov[k] && !seen[k]) begin
                    seen[k] = 1'b1;
                    lat[k]  = n;
                    res[k]  = od[k];
                end
            end
            if (seen[0] && seen[1] && seen[2] && seen[3]) break;
            @(negedge clk);
        end
        in_inv = inv;
        for (int k = 0; k < 4; k++)
            chk($sformatf("latency u%0d", k), 128'(lat[k]), 128'(EXPLAT[k]));
    endtask

    initial begin
        int           n;
        logic [127:0] d;
        logic [127:0] e;
        logic [127:0] snap;
        logic [127:0] r35;

        r35 = 128'h76abd7fe2b670130c56f6bf27b777c63;

        #2 rst_n = 1'b0;
        #1;
        for (int k = 0; k < 4; k++) begin
            chk($sformatf("rst out_valid u%0d", k), 128'(ov[k]), 128'd0);
            chk($sformatf("rst in_ready u%0d", k), 128'(ir[k]), 128'd1);
            chk($sformatf("rst busy u%0d", k), 128'(bz[k]), 128'd0);
            chk($sformatf("rst out_data u%0d", k), od[k], 128'd0);
        end
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        d = 128'h0f0e0d0c0b0a09080706050403020100;
        run(d, 1'b0, 1'b0);
        for (int k = 0; k < 4; k++)
            chk($sformatf("fwd 00..0f u%0d", k), res[k], r35);

        run(r35, 1'b1, 1'b1);
        for (int k = 0; k < 4; k++)
            chk($sformatf("inv toggled u%0d", k), res[k], d);

        // backpressure on a held DONE, with a stray input pulse
        out_ready = 1'b0;
        d         = 128'h00112233445566778899aabbccddeeff;
        in_data   = d;
        in_inv    = 1'b0;
        in_valid  = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        n = 0;
        while (!ov[0] && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("bp reached done", 128'(ov[0]), 128'd1);
        snap = od[0];
        chk("bp result", snap, fwdblk(d));
        for (int i = 0; i < 10; i++) begin
            chk($sformatf("bp out_valid %0d", i), 128'(ov[0]), 128'd1);
            chk($sformatf("bp stable %0d", i), od[0], snap);
            chk($sformatf("bp in_ready %0d", i), 128'(ir[0]), 128'd0);
            if (i == 3) begin
                in_data  = 128'hffeeddccbbaa99887766554433221100;
                in_valid = 1'b1;
            end else begin
                in_valid = 1'b0;
            end
            @(negedge clk);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        chk("bp idle in_ready", 128'(ir[0]), 128'd1);
        chk("bp idle out_valid", 128'(ov[0]), 128'd0);
        chk("bp retained", od[0], snap);

        // reset while u0 is at cnt == 2
        d        = 128'h0123456789abcdef0123456789abcdef;
        in_data  = d;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("mid busy", 128'(bz[0]), 128'd1);
        rst_n = 1'b0;
        #1;
        chk("mid rst out_valid", 128'(ov[0]), 128'd0);
        chk("mid rst out_data", od[0], 128'd0);
        chk("mid rst busy", 128'(bz[0]), 128'd0);
        chk("mid rst in_ready", 128'(ir[0]), 128'd1);
        @(negedge clk);
        rst_n = 1'b1;
        d = 128'hff53000102030405060708090a0b0cff;
        run(d, 1'b0, 1'b0);
        for (int k = 0; k < 4; k++)
            chk($sformatf("post rst u%0d", k), res[k], fwdblk(d));

        // every byte value, both directions, all instances
        for (int b = 0; b < 16; b++) begin
            for (int j = 0; j < 16; j++) d[8*j +: 8] = 8'(16*b + j);
            e = fwdblk(d);
            run(d, 1'b0, 1'b0);
            for (int k = 0; k < 4; k++)
                chk($sformatf("sweep fwd blk%0d u%0d", b, k), res[k], e);
            run(e, 1'b1, 1'b0);
            for (int k = 0; k < 4; k++)
                chk($sformatf("sweep inv blk%0d u%0d", b, k), res[k], d);
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
